// File: rtl/alu_serial_rx.sv
// alu_serial_rx: deserialises 11-bit frames into a {B,A,OP} operand packet for the ALU core.
// Define ALU_SERIAL_RX_STATS_EN to add saturating good/error packet counters.
module alu_serial_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [2:0]  op_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [3:0]  err_o,
  output logic        err_valid_o,
  output logic        busy_o
`ifdef ALU_SERIAL_RX_STATS_EN
  ,
  output logic [15:0] pkt_ok_cnt_o,
  output logic [15:0] pkt_err_cnt_o
`endif
);

  localparam logic [3:0] ERR_NONE = 4'b0000;
  localparam logic [3:0] ERR_OP   = 4'b0001;
  localparam logic [3:0] ERR_CRC  = 4'b0010;
  localparam logic [3:0] ERR_DATA = 4'b0100;
  localparam logic [3:0] ERR_OVR  = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TYPE   = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_RESYNC = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_bit_cnt;
  logic        r_type;
  logic [7:0]  r_shift;
  logic [3:0]  r_byte_cnt;
  logic [63:0] r_ba;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_op;
  logic        r_valid;
  logic [3:0]  r_err;
  logic        r_err_valid;
  logic        r_busy;

  logic        w_frame_done;
  logic        w_frame_bad;
  logic [3:0]  w_cnt_nxt;
  logic [63:0] w_ba_nxt;
  logic [3:0]  w_err_code;
  logic        w_err_pulse;
  logic        w_good;
  logic [3:0]  w_crc_calc;

  // CRC-4, polynomial x^4+x+1, zero init, MSB first over {B,A,1'b1,OP}
  function automatic logic [3:0] crc4_68(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b100, 3'b101: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  assign w_crc_calc = crc4_68({r_ba, 1'b1, r_shift[6:4]});

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame FSM next state and end-of-frame strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    w_frame_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!sin) begin
          w_state_nxt = S_TYPE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TYPE: w_state_nxt = S_DATA;
      S_DATA: begin
        if (r_bit_cnt == 3'd0) begin
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_STOP: begin
        if (sin) begin
          w_frame_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_frame_bad  = 1'b1;
          w_state_nxt  = S_RESYNC;
        end
      end
      S_RESYNC: begin
        if (sin) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESYNC;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame bit capture: type flag and data byte, MSB first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt <= 3'd0;
      r_type    <= 1'b0;
      r_shift   <= 8'h00;
    end else begin
      case (r_state)
        S_TYPE: begin
          r_type    <= sin;
          r_bit_cnt <= 3'd7;
        end
        S_DATA: begin
          r_shift   <= {r_shift[6:0], sin};
          r_bit_cnt <= r_bit_cnt - 3'd1;
        end
        default: r_bit_cnt <= r_bit_cnt;
      endcase
    end
  end

  // Byte dispatch and packet checks; checks are resolved on the stop-bit edge
  always_comb begin
    w_cnt_nxt   = r_byte_cnt;
    w_ba_nxt    = r_ba;
    w_err_code  = ERR_NONE;
    w_err_pulse = 1'b0;
    w_good      = 1'b0;
    if (w_frame_bad) begin
      w_cnt_nxt   = 4'd0;
      w_err_code  = ERR_DATA;
      w_err_pulse = 1'b1;
    end else if (w_frame_done) begin
      if (!r_type) begin
        if (r_byte_cnt < 4'd8) begin
          w_ba_nxt  = {r_ba[55:0], r_shift};
          w_cnt_nxt = r_byte_cnt + 4'd1;
        end else begin
          w_cnt_nxt   = 4'd0;
          w_err_code  = ERR_DATA;
          w_err_pulse = 1'b1;
        end
      end else begin
        w_cnt_nxt = 4'd0;
        if (r_byte_cnt != 4'd8) begin
          w_err_code  = ERR_DATA;
          w_err_pulse = 1'b1;
        end else if (w_crc_calc != r_shift[3:0]) begin
          w_err_code  = ERR_CRC;
          w_err_pulse = 1'b1;
        end else if (!op_legal(r_shift[6:4])) begin
          w_err_code  = ERR_OP;
          w_err_pulse = 1'b1;
        end else if (r_valid && !ready_i) begin
          w_err_code  = ERR_OVR;
          w_err_pulse = 1'b1;
        end else begin
          w_good = 1'b1;
        end
      end
    end else begin
      w_cnt_nxt = r_byte_cnt;
    end
  end

  // Packet assembly, output hold/handshake and error pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte_cnt  <= 4'd0;
      r_ba        <= 64'h0;
      r_a         <= 32'h0;
      r_b         <= 32'h0;
      r_op        <= 3'b000;
      r_valid     <= 1'b0;
      r_err       <= ERR_NONE;
      r_err_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_byte_cnt  <= w_cnt_nxt;
      r_ba        <= w_ba_nxt;
      r_err       <= w_err_code;
      r_err_valid <= w_err_pulse;
      r_busy      <= (w_cnt_nxt != 4'd0) || (w_state_nxt != S_IDLE);
      if (w_good) begin
        r_b     <= r_ba[63:32];
        r_a     <= r_ba[31:0];
        r_op    <= r_shift[6:4];
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign a_o         = r_a;
  assign b_o         = r_b;
  assign op_o        = r_op;
  assign valid_o     = r_valid;
  assign err_o       = r_err;
  assign err_valid_o = r_err_valid;
  assign busy_o      = r_busy;

`ifdef ALU_SERIAL_RX_STATS_EN
  logic [15:0] r_ok_cnt;
  logic [15:0] r_err_cnt;

  // Saturating good/error packet counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ok_cnt  <= 16'h0000;
      r_err_cnt <= 16'h0000;
    end else begin
      if (w_good && (r_ok_cnt != 16'hFFFF)) begin
        r_ok_cnt <= r_ok_cnt + 16'd1;
      end
      if (w_err_pulse && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign pkt_ok_cnt_o  = r_ok_cnt;
  assign pkt_err_cnt_o = r_err_cnt;
`else
  // No statistics in this build.
`endif

endmodule

// File: tb/tb_alu_serial_rx.sv
// Randomised directed bench for alu_serial_rx; expectations come from a packet-level model
// with CRC computed by polynomial long division.
module tb_alu_serial_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic        ready_i;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic [2:0]  op_o;
  logic        valid_o;
  logic [3:0]  err_o;
  logic        err_valid_o;
  logic        busy_o;
`ifdef ALU_SERIAL_RX_STATS_EN
  logic [15:0] pkt_ok_cnt_o;
  logic [15:0] pkt_err_cnt_o;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic        exp_valid;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [2:0]  exp_op;
  int          exp_ok;
  int          exp_errs;

  always #5 clk = ~clk;

  alu_serial_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .a_o         (a_o),
    .b_o         (b_o),
    .op_o        (op_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .err_o       (err_o),
    .err_valid_o (err_valid_o),
    .busy_o      (busy_o)
`ifdef ALU_SERIAL_RX_STATS_EN
    ,
    .pkt_ok_cnt_o  (pkt_ok_cnt_o),
    .pkt_err_cnt_o (pkt_err_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remainder of ({B,A,1,OP} * x^4) divided by x^4+x+1
  function automatic logic [3:0] ref_crc(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    end
    return m[3:0];
  endfunction

  function automatic logic op_ok(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd5);
  endfunction

  task automatic bit_out(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic typ, input logic [7:0] d, input logic stopb);
    bit_out(1'b0);
    bit_out(typ);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_out(stopb);
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] e);
    chk({tag, "_errv"}, err_valid_o, (e != 4'd0));
    if (e != 4'd0) chk({tag, "_err"}, err_o, e);
    chk({tag, "_valid"}, valid_o, exp_valid);
    chk({tag, "_a"}, a_o, exp_a);
    chk({tag, "_b"}, b_o, exp_b);
    chk({tag, "_op"}, op_o, exp_op);
`ifdef ALU_SERIAL_RX_STATS_EN
    chk({tag, "_okcnt"}, pkt_ok_cnt_o, exp_ok);
    chk({tag, "_errcnt"}, pkt_err_cnt_o, exp_errs);
`endif
  endtask

  task automatic apply_packet(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic [3:0] crc,
                              input int nbytes, input logic rdy);
    logic [63:0] ba;
    logic [7:0]  ctl;
    logic [3:0]  e;
    ba  = {b, a};
    ctl = {1'b0, op, crc};
    ready_i = 1'b0;
    for (int k = 0; k < nbytes; k++) frame(1'b0, ba[63 - 8*k -: 8], 1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    for (int i = 7; i >= 0; i--) bit_out(ctl[i]);
    ready_i = rdy;
    bit_out(1'b1);
    if (nbytes != 8)                e = 4'b0100;
    else if (ref_crc(a, b, op) != crc) e = 4'b0010;
    else if (!op_ok(op))            e = 4'b0001;
    else if (exp_valid && !rdy)     e = 4'b1000;
    else                            e = 4'b0000;
    if (e == 4'd0) begin
      exp_a = a; exp_b = b; exp_op = op; exp_valid = 1'b1; exp_ok++;
    end else begin
      exp_errs++;
      if (exp_valid && rdy) exp_valid = 1'b0;
    end
    check_outputs(tag, e);
    bit_out(1'b1);
    if (exp_valid && rdy) exp_valid = 1'b0;
    chk({tag, "_pulse_end"}, err_valid_o, 1'b0);
    chk({tag, "_valid2"}, valid_o, exp_valid);
    ready_i = 1'b0;
  endtask

  task automatic handshake(input string tag);
    ready_i = 1'b1;
    bit_out(1'b1);
    exp_valid = 1'b0;
    chk(tag, valid_o, exp_valid);
    ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic [3:0]  rcrc;
    logic [63:0] ba;
    logic [2:0]  legal_ops [4];
    legal_ops = '{3'd0, 3'd1, 3'd4, 3'd5};

    rst_n = 1'b0; sin = 1'b1; ready_i = 1'b0;
    exp_valid = 1'b0; exp_a = 32'h0; exp_b = 32'h0; exp_op = 3'd0; exp_ok = 0; exp_errs = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 4'd0);
    chk("reset_err", err_o, 4'd0);
    chk("reset_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    bit_out(1'b1);

    // Basic ADD packet, then handshake
    apply_packet("t1", 32'h5, 32'h3, 3'b100, ref_crc(32'h5, 32'h3, 3'b100), 8, 1'b0);
    chk("t1_busy", busy_o, 1'b0);
    handshake("t1_hs");

    apply_packet("t2_crc", 32'h5, 32'h3, 3'b100, ref_crc(32'h5, 32'h3, 3'b100) ^ 4'b0001, 8, 1'b0);

    ra = $urandom; rb = $urandom;
    apply_packet("t3_op", ra, rb, 3'b010, ref_crc(ra, rb, 3'b010), 8, 1'b0);
    apply_packet("t3_short", ra, rb, 3'b100, ref_crc(ra, rb, 3'b100), 7, 1'b0);

    // Bad stop bit in DATA byte 3, then recovery
    ra = $urandom; rb = $urandom; ba = {rb, ra};
    for (int k = 0; k < 3; k++) frame(1'b0, ba[63 - 8*k -: 8], 1'b1);
    frame(1'b0, ba[39:32], 1'b0);
    exp_errs++;
    check_outputs("t4_stop", 4'b0100);
    bit_out(1'b1);
    chk("t4_pulse_end", err_valid_o, 1'b0);
    bit_out(1'b1);
    ra = $urandom; rb = $urandom; rop = legal_ops[$urandom_range(0, 3)];
    apply_packet("t4_good", ra, rb, rop, ref_crc(ra, rb, rop), 8, 1'b0);
    handshake("t4_hs");

    // Back-pressure: hold, overrun, then load coincident with handshake
    ra = $urandom; rb = $urandom; rop = legal_ops[$urandom_range(0, 3)];
    apply_packet("t5_first", ra, rb, rop, ref_crc(ra, rb, rop), 8, 1'b0);
    repeat (5) bit_out(1'b1);
    check_outputs("t5_hold", 4'd0);
    ra = $urandom; rb = $urandom; rop = legal_ops[$urandom_range(0, 3)];
    apply_packet("t5_ovr", ra, rb, rop, ref_crc(ra, rb, rop), 8, 1'b0);
    ra = $urandom; rb = $urandom; rop = legal_ops[$urandom_range(0, 3)];
    apply_packet("t5_same", ra, rb, rop, ref_crc(ra, rb, rop), 8, 1'b1);

    // Random mix of opcodes, CRC corruption, short packets and ready timing
    for (int n = 0; n < 10; n++) begin
      ra = $urandom; rb = $urandom; rop = 3'($urandom_range(0, 7));
      rcrc = ref_crc(ra, rb, rop);
      if ($urandom_range(0, 3) == 0) rcrc = rcrc ^ 4'($urandom_range(1, 15));
      apply_packet("rnd", ra, rb, rop, rcrc, ($urandom_range(0, 9) == 0) ? 7 : 8,
                   1'($urandom_range(0, 1)));
    end

    // Reset in the middle of A byte 2
    ra = $urandom; rb = $urandom; ba = {rb, ra};
    for (int k = 0; k < 6; k++) frame(1'b0, ba[63 - 8*k -: 8], 1'b1);
    bit_out(1'b0); bit_out(1'b0); bit_out(ba[15]); bit_out(ba[14]); bit_out(ba[13]);
    chk("t6_busy_mid", busy_o, 1'b1);
    rst_n = 1'b0; sin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_valid = 1'b0; exp_a = 32'h0; exp_b = 32'h0; exp_op = 3'd0; exp_ok = 0; exp_errs = 0;
    check_outputs("t6_reset", 4'd0);
    chk("t6_busy_rst", busy_o, 1'b0);
    rst_n = 1'b1;
    bit_out(1'b1);
    ra = $urandom; rb = $urandom; rop = legal_ops[$urandom_range(0, 3)];
    apply_packet("t6_good", ra, rb, rop, ref_crc(ra, rb, rop), 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
